// File: rtl/contador_updown_param.sv
// Purpose     : synchronous parametrised up/down counter with modulo, load, clear, prescaler, wrap/saturate.
// Latency     : count/wrap/sat registered, update on the edge a clear/load/step is sampled; tc is combinational.
// Backpressure: none; en gates the prescaler, and a step is taken whenever the prescaler completes a period.
//
// Ports
//   clk      : single system clock, all state on the rising edge
//   rstn     : asynchronous active-low reset
//   clear    : synchronous clear (highest priority)
//   load     : synchronous parallel load of load_val, clamped to MODULO-1
//   load_val : value to load
//   en       : count enable into the prescaler
//   up       : direction, 1 = up, 0 = down, sampled on each step
//   count    : current count (registered)
//   tc       : terminal count, en & step & at the range end in the current direction
//   wrap     : 1-cycle pulse, previous edge wrapped around the range (SATURATE=0)
//   sat      : level, count held at a range end by a blocked step (SATURATE=1)
module contador_updown_param #(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 256,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // Prescaler counter needs at least one bit even when PRESCALE=1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Range top held in WIDTH+1 bits so MODULO = 2**WIDTH is representable
    // without overflow in the comparisons below.
    localparam logic [WIDTH:0]  MAX_VAL = (WIDTH+1)'(MODULO - 1);
    localparam logic [PW-1:0]   P_LAST  = PW'(PRESCALE - 1);

    logic [PW-1:0]  pcnt;
    logic [PW-1:0]  pcnt_nxt;
    logic           step;

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic           at_top;
    logic           at_bot;
    logic           at_end;

    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] load_clamped;

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    // ------------------------------------------------------------------
    // Step generation: one step per PRESCALE enabled cycles.
    // ------------------------------------------------------------------
    assign step = en & (pcnt == P_LAST);

    // ------------------------------------------------------------------
    // Range arithmetic in WIDTH+1 bits. Incrementing past MAX_VAL or a
    // borrow out of the top bit on decrement marks the range ends.
    // ------------------------------------------------------------------
    assign cnt_ext = {1'b0, count};
    assign inc_ext = cnt_ext + {{WIDTH{1'b0}}, 1'b1};
    assign dec_ext = cnt_ext - {{WIDTH{1'b0}}, 1'b1};
    assign at_top  = (inc_ext > MAX_VAL);
    assign at_bot  = dec_ext[WIDTH];
    assign at_end  = up ? at_top : at_bot;

    // Out-of-range load values clamp to the top of the range.
    assign load_ext     = {1'b0, load_val};
    assign load_clamped = (load_ext > MAX_VAL) ? MAX_VAL : load_ext;

    // Terminal count reflects a step that would hit the end this edge;
    // clear and load take priority over the step, so they mask it.
    assign tc = step & at_end & ~clear & ~load;

    // ------------------------------------------------------------------
    // Next-state selection: clear > load > step > hold.
    // ------------------------------------------------------------------
    always_comb begin
        count_nxt = count;
        pcnt_nxt  = pcnt;
        wrap_nxt  = 1'b0;
        sat_nxt   = sat;

        if (clear) begin
            count_nxt = '0;
            pcnt_nxt  = '0;
            sat_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = load_clamped[WIDTH-1:0];
            pcnt_nxt  = '0;
            sat_nxt   = 1'b0;
        end else if (en) begin
            if (step) begin
                pcnt_nxt = '0;
                if (!at_end) begin
                    count_nxt = up ? inc_ext[WIDTH-1:0] : dec_ext[WIDTH-1:0];
                    sat_nxt   = 1'b0;
                end else if (SATURATE != 0) begin
                    // Blocked step: hold the end value and flag it.
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = up ? '0 : MAX_VAL[WIDTH-1:0];
                    wrap_nxt  = 1'b1;
                end
            end else begin
                pcnt_nxt = pcnt + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
            pcnt  <= '0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= count_nxt;
            pcnt  <= pcnt_nxt;
            wrap  <= wrap_nxt;
            sat   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_contador_updown_param.sv
// Purpose : self-checking bench for contador_updown_param, four configurations driven in parallel.
// Latency : outputs sampled 1 time unit after the rising edge, tc sampled mid-low-phase.
// Backpressure: none; stimulus is cycle-paced.
module tb_contador_updown_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       clear;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] load_val;

    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic [7:0] cnt_d;
    logic [3:0] tc_v, wrap_v, sat_v;

    // 0: W4 M10 P1 wrap   1: W4 M10 P1 saturate   2: W4 M10 P3 wrap   3: W8 M256 P1 wrap
    contador_updown_param #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(0)) u_a (
        .clk(clk), .rstn(rstn), .clear(clear), .load(load), .load_val(load_val[3:0]),
        .en(en), .up(up), .count(cnt_a), .tc(tc_v[0]), .wrap(wrap_v[0]), .sat(sat_v[0]));
    contador_updown_param #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(1)) u_b (
        .clk(clk), .rstn(rstn), .clear(clear), .load(load), .load_val(load_val[3:0]),
        .en(en), .up(up), .count(cnt_b), .tc(tc_v[1]), .wrap(wrap_v[1]), .sat(sat_v[1]));
    contador_updown_param #(.WIDTH(4), .MODULO(10), .PRESCALE(3), .SATURATE(0)) u_c (
        .clk(clk), .rstn(rstn), .clear(clear), .load(load), .load_val(load_val[3:0]),
        .en(en), .up(up), .count(cnt_c), .tc(tc_v[2]), .wrap(wrap_v[2]), .sat(sat_v[2]));
    contador_updown_param #(.WIDTH(8), .MODULO(256), .PRESCALE(1), .SATURATE(0)) u_d (
        .clk(clk), .rstn(rstn), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(cnt_d), .tc(tc_v[3]), .wrap(wrap_v[3]), .sat(sat_v[3]));

    int n_checks = 0;
    int n_fail   = 0;

    // Configuration table for the reference model.
    int cfg_mod [4] = '{10, 10, 10, 256};
    int cfg_pre [4] = '{1, 1, 3, 1};
    int cfg_sat [4] = '{0, 1, 0, 0};
    int cfg_mask[4] = '{15, 15, 15, 255};

    // Reference model state: plain integers.
    int m_cnt [4];
    int m_pc  [4];
    int m_wrap[4];
    int m_sat [4];

    function automatic logic [31:0] dut_count(input int i);
        case (i)
            0:       return {28'd0, cnt_a};
            1:       return {28'd0, cnt_b};
            2:       return {28'd0, cnt_c};
            default: return {24'd0, cnt_d};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_pc[i]   = 0;
            m_wrap[i] = 0;
            m_sat[i]  = 0;
        end
    endtask

    task automatic check_state(input string ph);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s count[%0d]", ph, i), dut_count(i), m_cnt[i]);
            check($sformatf("%s wrap[%0d]", ph, i), {31'd0, wrap_v[i]}, m_wrap[i]);
            check($sformatf("%s sat[%0d]", ph, i), {31'd0, sat_v[i]}, m_sat[i]);
        end
    endtask

    // Apply one cycle of inputs, check tc before the edge, advance the model, check after.
    task automatic cycle(input bit c, input bit l, input bit e, input bit u, input int lv);
        int last;
        int exp_tc;
        int lvm;
        @(negedge clk);
        clear    = c;
        load     = l;
        en       = e;
        up       = u;
        load_val = lv[7:0];
        #1;
        for (int i = 0; i < 4; i++) begin
            last   = cfg_mod[i] - 1;
            exp_tc = (e && !c && !l && m_pc[i] == cfg_pre[i] - 1 &&
                      (u ? (m_cnt[i] == last) : (m_cnt[i] == 0))) ? 1 : 0;
            check($sformatf("tc[%0d]", i), {31'd0, tc_v[i]}, exp_tc);

            if (c) begin
                m_cnt[i] = 0; m_pc[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
            end else if (l) begin
                lvm      = lv & cfg_mask[i];
                m_cnt[i] = (lvm > last) ? last : lvm;
                m_pc[i]  = 0; m_wrap[i] = 0; m_sat[i] = 0;
            end else if (e) begin
                m_wrap[i] = 0;
                if (m_pc[i] != cfg_pre[i] - 1) begin
                    m_pc[i]++;
                end else begin
                    m_pc[i] = 0;
                    if (u && m_cnt[i] < last) begin
                        m_cnt[i]++; m_sat[i] = 0;
                    end else if (!u && m_cnt[i] > 0) begin
                        m_cnt[i]--; m_sat[i] = 0;
                    end else if (cfg_sat[i] != 0) begin
                        m_sat[i] = 1;
                    end else begin
                        m_cnt[i]  = u ? 0 : last;
                        m_wrap[i] = 1;
                    end
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        check_state("step");
    endtask

    // Reset asserted between edges must take effect without a clock edge.
    task automatic async_reset();
        @(negedge clk);
        en = 1'b0; clear = 1'b0; load = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        @(posedge clk);
        #1;
        check_state("rst_hold");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bit u_r;
        rstn = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        for (int i = 0; i < 4; i++) check($sformatf("reset tc[%0d]", i), {31'd0, tc_v[i]}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Count up through the wrap.
        repeat (12) cycle(0, 0, 1, 1, 0);
        // Count down, wrap at 0, then reverse mid-run.
        repeat (5) cycle(0, 0, 1, 0, 0);
        repeat (3) cycle(0, 0, 1, 1, 0);
        repeat (4) cycle(0, 0, 1, 0, 0);
        // Run into both ends (saturation on instance 1).
        repeat (14) cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (14) cycle(0, 0, 1, 0, 0);
        // Prescaler phase retention and restart on load.
        repeat (4) cycle(0, 0, 1, 1, 0);
        repeat (2) cycle(0, 0, 0, 1, 0);
        repeat (3) cycle(0, 0, 1, 1, 0);
        cycle(0, 1, 1, 1, 3);
        repeat (5) cycle(0, 0, 1, 1, 0);
        // Priority and clamping.
        cycle(1, 1, 1, 1, 5);
        cycle(0, 1, 0, 1, 13);
        cycle(0, 1, 1, 1, 7);
        // Full-range wrap on the 8-bit counter, both directions.
        cycle(0, 1, 0, 1, 255);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // Mid-prescale async reset, then count on the first edge after release.
        cycle(0, 0, 1, 1, 0);
        async_reset();
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);

        // Randomised phase.
        u_r = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) u_r = ~u_r;
            if ($urandom_range(0, 149) == 0) async_reset();
            cycle($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, u_r, int'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
